// File: rtl/mmu_pkg.sv
// Shared types and sizing helpers for the matrix-multiply feeders and result capture.
// No logic; constant functions only.
package mmu_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_t;

    // Zero shifts needed after the last vector: empty the skew, then cross the array.
    function automatic int drain_cycles(input int length);
        return 2 * length - 1;
    endfunction

    function automatic int cnt_width(input int length);
        return (length > 1) ? $clog2(2 * length) : 1;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// DEPTH-stage shift register for one feeder lane.
// Latency DEPTH shifts; holds its contents whenever shift_en is low.
module skew_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [0:DEPTH-1];
    logic [WIDTH-1:0] stage_d [0:DEPTH-1];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (shift_en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonally skews accepted vectors into the systolic array, then drains zeros and pulses DONE.
// Lane k shows a vector k+1 shifts after accept; a stalled producer freezes every lane.
module systolic_skew_feeder #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 256
) (
    input  logic             CLK,
    input  logic             ASYNC_RST,
    input  logic             SYNC_RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_LAST,
    input  logic [WIDTH-1:0] IN_DATA  [0:LENGTH-1],
    output logic [WIDTH-1:0] OUT_DATA [0:LENGTH-1],
    output logic             OUT_EN,
    output logic             BUSY,
    output logic             DONE
);
    import mmu_pkg::*;

    localparam int              CNT_W      = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(drain_cycles(LENGTH) - 1);

    feeder_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_en_q, out_en_d;
    logic             rdy_q, rdy_d;
    logic             in_ready, xfer, shift;
    logic [WIDTH-1:0] lane_in [0:LENGTH-1];

    // The port DONE shadows the imported state literal, so that one is qualified.
    always_comb begin
        in_ready = rdy_q && !SYNC_RST && (state_q == IDLE || state_q == STREAM);
        xfer     = IN_VALID && in_ready;
        shift    = xfer || (state_q == DRAIN);
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_en_d = shift;
        rdy_d    = 1'b1;
        case (state_q)
            IDLE, STREAM: begin
                if (xfer) begin
                    if (IN_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = mmu_pkg::DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (SYNC_RST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            out_en_d = 1'b0;
            rdy_d    = 1'b0;
        end
    end

    // rdy_q keeps IN_READY low for the first cycle out of any reset.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_en_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_en_q <= out_en_d;
            rdy_q    <= rdy_d;
        end
    end

    for (genvar k = 0; k < LENGTH; k++) begin : g_lane
        assign lane_in[k] = xfer ? IN_DATA[k] : '0;

        skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH (k + 1)
        ) u_lane (
            .clk      (CLK),
            .rst_n    (ASYNC_RST),
            .clr      (SYNC_RST),
            .shift_en (shift),
            .din      (lane_in[k]),
            .dout     (OUT_DATA[k])
        );
    end

    assign IN_READY = in_ready;
    assign OUT_EN   = out_en_q;
    assign BUSY     = (state_q != IDLE);
    assign DONE     = (state_q == mmu_pkg::DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed scenarios plus randomized traffic against a vector-history model.
module tb_systolic_skew_feeder;

    localparam int W = 8;
    localparam int L = 4;
    typedef logic [L-1:0][W-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         arst_n, srst, in_valid, in_last, in_ready, out_en, busy, done;
    logic [W-1:0] in_data  [0:L-1];
    logic [W-1:0] out_data [0:L-1];

    logic         srst1, in_valid1, in_last1, in_ready1, out_en1, busy1, done1;
    logic [W-1:0] in_data1  [0:0];
    logic [W-1:0] out_data1 [0:0];

    int checks = 0;
    int errors = 0;

    systolic_skew_feeder #(.WIDTH(W), .LENGTH(L)) dut (
        .CLK(clk), .ASYNC_RST(arst_n), .SYNC_RST(srst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_LAST(in_last), .IN_DATA(in_data), .OUT_DATA(out_data), .OUT_EN(out_en),
        .BUSY(busy), .DONE(done)
    );

    systolic_skew_feeder #(.WIDTH(W), .LENGTH(1)) dut1 (
        .CLK(clk), .ASYNC_RST(arst_n), .SYNC_RST(srst1), .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .IN_LAST(in_last1), .IN_DATA(in_data1), .OUT_DATA(out_data1), .OUT_EN(out_en1),
        .BUSY(busy1), .DONE(done1)
    );

    // Reference model: hist[j] is the vector fed in j shifts ago, so lane k shows hist[k][k].
    vec_t hist [0:L-1];
    int   m_phase;       // 0 idle, 1 streaming, 2 draining, 3 done
    int   m_drain_left;
    bit   m_out_en;
    bit   m_fresh;

    function automatic bit exp_ready();
        return !m_fresh && (m_phase <= 1);
    endfunction

    task automatic model_reset();
        for (int j = 0; j < L; j++) hist[j] = '0;
        m_phase = 0; m_drain_left = 0; m_out_en = 0; m_fresh = 1;
    endtask

    task automatic model_step(input bit v, input bit last, input vec_t d, input bit sr, output bit acc);
        bit sh;
        acc = 0;
        if (sr) begin
            model_reset();
            return;
        end
        acc = v && exp_ready();
        sh  = acc || (m_phase == 2);
        m_out_en = sh;
        if (sh) begin
            for (int j = L - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = acc ? d : '0;
        end
        m_fresh = 0;
        case (m_phase)
            0, 1: if (acc) begin
                if (last) begin m_phase = 2; m_drain_left = 2 * L - 1; end
                else m_phase = 1;
            end
            2: begin
                m_drain_left--;
                if (m_drain_left == 0) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    // Called at a negedge; returns at the following negedge with the model advanced.
    task automatic drive(input bit v, input bit last, input vec_t d, input bit sr, output bit acc);
        in_valid = v; in_last = last; srst = sr;
        for (int k = 0; k < L; k++) in_data[k] = d[k];
        @(posedge clk);
        model_step(v, last, d, sr, acc);
        @(negedge clk);
        in_valid = 0; in_last = 0; srst = 0;
    endtask

    task automatic test_reset();
        bit acc;
        #2;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %b want 0", out_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        for (int k = 0; k < L; k++) begin
            checks++;
            if (out_data[k] !== '0) begin errors++; $display("FAIL reset_lane%0d got %h want 00", k, out_data[k]); end
        end
        @(negedge clk);
        arst_n = 1;
        drive(0, 0, '0, 0, acc);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got %b want 1", in_ready1); end
    endtask

    task automatic test_single();
        vec_t d;
        bit   acc;
        int   done_at = -1;
        d = {8'd4, 8'd3, 8'd2, 8'd1};
        drive(1, 1, d, 0, acc);
        checks++; if (!acc) begin errors++; $display("FAIL single_accept got 0 want 1"); end
        for (int i = 1; i <= 10; i++) begin
            for (int k = 0; k < L; k++) begin
                if (i == k + 1) begin
                    checks++;
                    if (out_data[k] !== W'(k + 1)) begin
                        errors++; $display("FAIL single_lane%0d_t%0d got %0d want %0d", k, i, out_data[k], k + 1);
                    end
                end
            end
            checks++; if (out_en !== m_out_en) begin errors++; $display("FAIL single_out_en_t%0d got %b want %b", i, out_en, m_out_en); end
            checks++; if (done !== (m_phase == 3)) begin errors++; $display("FAIL single_done_t%0d got %b want %b", i, done, m_phase == 3); end
            if (done === 1'b1 && done_at < 0) done_at = i;
            drive(0, 0, '0, 0, acc);
        end
        checks++; if (done_at != 2 * L) begin errors++; $display("FAIL single_done_cycle got %0d want %0d", done_at, 2 * L); end
    endtask

    task automatic test_stream(input int gap);
        bit   acc, v, lst;
        logic [W-1:0] val;
        int   ti;
        int   done_at = -1;
        for (int c = 0; c < 14 + gap; c++) begin
            v = 0; lst = 0; val = '0;
            if (c == 0) begin v = 1; val = 8'd1; end
            else if (c == gap + 1) begin v = 1; val = 8'd2; end
            else if (c == gap + 2) begin v = 1; lst = 1; val = 8'd3; end
            drive(v, lst, {L{val}}, 0, acc);
            ti = c + 1;
            for (int k = 0; k < L; k++) begin
                checks++;
                if (out_data[k] !== hist[k][k]) begin
                    errors++; $display("FAIL stream%0d_lane%0d_t%0d got %h want %h", gap, k, ti, out_data[k], hist[k][k]);
                end
            end
            if (ti >= 4 + gap && ti <= 6 + gap) begin
                checks++;
                if (out_data[L-1] !== W'(ti - 3 - gap)) begin
                    errors++; $display("FAIL stream%0d_lane3_seq_t%0d got %0d want %0d", gap, ti, out_data[L-1], ti - 3 - gap);
                end
            end
            if (gap > 0 && (ti == 2 || ti == 3)) begin
                checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL stall_out_en_t%0d got %b want 0", ti, out_en); end
            end
            checks++; if (out_en !== m_out_en) begin errors++; $display("FAIL stream%0d_out_en_t%0d got %b want %b", gap, ti, out_en, m_out_en); end
            checks++; if (busy !== (m_phase != 0)) begin errors++; $display("FAIL stream%0d_busy_t%0d got %b want %b", gap, ti, busy, m_phase != 0); end
            if (done === 1'b1 && done_at < 0) done_at = ti;
        end
        checks++;
        if (done_at != gap + 2 + 2 * L) begin
            errors++; $display("FAIL stream%0d_done_cycle got %0d want %0d", gap, done_at, gap + 2 + 2 * L);
        end
    endtask

    task automatic test_sync_rst();
        bit acc;
        int done_at = -1;
        drive(1, 0, {L{8'h11}}, 0, acc);
        drive(1, 0, {L{8'h22}}, 0, acc);
        drive(0, 0, '0, 1, acc);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srst_busy got %b want 0", busy); end
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL srst_out_en got %b want 0", out_en); end
        for (int k = 0; k < L; k++) begin
            checks++;
            if (out_data[k] !== '0) begin errors++; $display("FAIL srst_lane%0d got %h want 00", k, out_data[k]); end
        end
        drive(0, 0, '0, 0, acc);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL srst_in_ready got %b want 1", in_ready); end
        drive(1, 1, {L{8'd9}}, 0, acc);
        checks++; if (!acc) begin errors++; $display("FAIL srst_new_accept got 0 want 1"); end
        for (int i = 1; i <= 10; i++) begin
            for (int k = 0; k < L; k++) begin
                checks++;
                if (out_data[k] !== hist[k][k]) begin
                    errors++; $display("FAIL srst_lane%0d_t%0d got %h want %h", k, i, out_data[k], hist[k][k]);
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = i;
            drive(0, 0, '0, 0, acc);
        end
        checks++; if (done_at != 2 * L) begin errors++; $display("FAIL srst_done_cycle got %0d want %0d", done_at, 2 * L); end
    endtask

    task automatic test_async_mid_drain();
        bit acc;
        drive(1, 1, {L{8'h5a}}, 0, acc);
        drive(0, 0, '0, 0, acc);
        drive(0, 0, '0, 0, acc);
        #2 arst_n = 0;
        #1;
        checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL arst_out_en got %b want 0", out_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", done); end
        for (int k = 0; k < L; k++) begin
            checks++;
            if (out_data[k] !== '0) begin errors++; $display("FAIL arst_lane%0d got %h want 00", k, out_data[k]); end
        end
        @(negedge clk);
        arst_n = 1;
        model_reset();
        drive(0, 0, '0, 0, acc);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_len1();
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL len1_ready_pre got %b want 1", in_ready1); end
        in_valid1 = 1; in_last1 = 1; in_data1[0] = 8'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 0; in_last1 = 0; in_data1[0] = 8'hee;
        checks++; if (out_data1[0] !== 8'd5) begin errors++; $display("FAIL len1_data got %0d want 5", out_data1[0]); end
        checks++; if (out_en1 !== 1'b1) begin errors++; $display("FAIL len1_out_en got %b want 1", out_en1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL len1_done_early got %b want 0", done1); end
        @(negedge clk);
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL len1_done got %b want 1", done1); end
        checks++; if (out_data1[0] !== 8'd0) begin errors++; $display("FAIL len1_drained got %0d want 0", out_data1[0]); end
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL len1_busy_after got %b want 0", busy1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL len1_ready_after got %b want 1", in_ready1); end
    endtask

    task automatic test_random();
        bit   acc, v, lst, sr;
        vec_t d;
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 9) < 7);
            lst = v && ($urandom_range(0, 9) < 2);
            sr  = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < L; k++) d[k] = W'($urandom);
            drive(v, lst, d, sr, acc);
            for (int k = 0; k < L; k++) begin
                checks++;
                if (out_data[k] !== hist[k][k]) begin
                    errors++; $display("FAIL rand_lane%0d_c%0d got %h want %h", k, c, out_data[k], hist[k][k]);
                end
            end
            checks++; if (out_en !== m_out_en) begin errors++; $display("FAIL rand_out_en_c%0d got %b want %b", c, out_en, m_out_en); end
            checks++; if (busy !== (m_phase != 0)) begin errors++; $display("FAIL rand_busy_c%0d got %b want %b", c, busy, m_phase != 0); end
            checks++; if (done !== (m_phase == 3)) begin errors++; $display("FAIL rand_done_c%0d got %b want %b", c, done, m_phase == 3); end
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready_c%0d got %b want %b", c, in_ready, exp_ready()); end
        end
    endtask

    initial begin
        arst_n = 0; srst = 0; in_valid = 0; in_last = 0;
        srst1 = 0; in_valid1 = 0; in_last1 = 0; in_data1[0] = '0;
        for (int k = 0; k < L; k++) in_data[k] = '0;
        model_reset();
        test_reset();
        test_single();
        test_stream(0);
        test_stream(2);
        test_sync_rst();
        test_async_mid_drain();
        test_len1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
